// File: rtl/udm_uart_pkg.sv
// Shared types and constants for the UART debug-channel receive path.
package udm_uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned MIN_BIT_DIV = 8;
    localparam int unsigned DIV_W       = 32;
    localparam int unsigned BIT_CNT_W   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Keep the bit period at or above the minimum the half-bit sampling can handle.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div);
        return (div < DIV_W'(MIN_BIT_DIV)) ? DIV_W'(MIN_BIT_DIV) : div;
    endfunction

endpackage : udm_uart_pkg

// File: rtl/udm_uart_rx_fifo.sv
// Received-byte buffer: synchronous FIFO with registered head byte and valid flag.
// A push into a full FIFO is dropped and flagged, unless a pop happens in the same cycle.
module udm_uart_rx_fifo
    import udm_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 valid,
    output logic                 ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_next;
    logic [PW-1:0]        rd_next;
    logic                 full_c;
    logic                 empty_c;
    logic                 push_ok;
    logic                 pop_ok;
    logic [DATA_BITS-1:0] rdata_d;

    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Accept/advance decisions and the head byte as it will look after this cycle.
    always_comb begin
        pop_ok  = pop && !empty_c;
        push_ok = push && (!full_c || pop_ok);
        wr_next = wr_ptr + PW'(push_ok);
        rd_next = rd_ptr + PW'(pop_ok);
        rdata_d = mem[rd_next[AW-1:0]];
        if (push_ok && (rd_next[AW-1:0] == wr_ptr[AW-1:0])) begin
            rdata_d = wdata;
        end
    end

    // Storage array write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointers plus registered head byte, valid flag and overflow pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            rdata  <= rdata_d;
            valid  <= (wr_next != rd_next);
            ovf    <= push && full_c && !pop_ok;
        end
    end

endmodule : udm_uart_rx_fifo

// File: rtl/udm_uart_rx.sv
// UART debug-channel receiver: rx synchroniser, bit-period divider, 8N1 deframer FSM
// and received-byte FIFO feeding the command decoder over valid/ready.
// Optional even parity bit after the data bits when UDM_UART_RX_PARITY_EN is defined.
module udm_uart_rx
    import udm_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 rx_i,
    input  logic [DIV_W-1:0]     bit_div_i,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 frame_err_o,
    output logic                 ovf_o,
    output logic                 busy_o
);

    rx_state_t              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [DIV_W-1:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0]       half_c;
    logic [BIT_CNT_W-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0]   sr_q, sr_d;
    logic                   par_err_q, par_err_d;
    logic                   frame_err_d;
    logic                   push_c;
    logic                   bit_end_c;

    // Metastability synchroniser; idle-high reset so no false start edge.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign half_c    = div_q >> 1;
    assign bit_end_c = (cnt_q == div_q - DIV_W'(1));

    // FSM state and datapath registers.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= IDLE;
            div_q       <= DIV_W'(MIN_BIT_DIV);
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            par_err_q   <= 1'b0;
            frame_err_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            par_err_q   <= par_err_d;
            frame_err_o <= frame_err_d;
            busy_o      <= (state_d != IDLE);
        end
    end

    // Next-state logic: every sample is taken at the centre of its bit.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        cnt_d       = cnt_q + DIV_W'(1);
        bit_d       = bit_q;
        sr_d        = sr_q;
        par_err_d   = par_err_q;
        frame_err_d = 1'b0;
        push_c      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    div_d     = clamp_div(bit_div_i);
                    par_err_d = 1'b0;
                end
            end

            START: begin
                if (cnt_q == half_c - DIV_W'(1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is high again at mid start bit was a glitch.
                    state_d = rx_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    sr_d  = {rx_s, sr_q[DATA_BITS-1:1]};
                    bit_d = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UDM_UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UDM_UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end_c) begin
                    cnt_d     = '0;
                    par_err_d = rx_s ^ (^sr_q);
                    state_d   = STOP;
                end
            end
`endif

            STOP: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end else if (par_err_q) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        push_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end

            BREAK: begin
                // Held-low line: wait for idle without repeating the error.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    udm_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (arst_n_i),
        .push  (push_c),
        .wdata (sr_q),
        .pop   (rready_i),
        .rdata (rdata_o),
        .valid (rvalid_o),
        .ovf   (ovf_o)
    );

endmodule : udm_uart_rx

// File: tb/tb_udm_uart_rx.sv
// Directed bench for udm_uart_rx: ideal serial frames at 868 clocks per bit.
// Define UDM_UART_RX_PARITY_EN to also exercise the parity frames.
module tb_udm_uart_rx;

    localparam int unsigned DIV  = 868;
    localparam int unsigned SYNC = 2;
`ifdef UDM_UART_RX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam int unsigned LAT_MIN = ((2 * FRAME_BITS - 1) * DIV) / 2;
    localparam int unsigned LAT_MAX = LAT_MIN + SYNC + 2;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        rx;
    logic [31:0] bit_div;
    logic [7:0]  rdata;
    logic        rvalid;
    logic        rready;
    logic        frame_err;
    logic        ovf;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          ferr_cnt = 0;
    int          ovf_cnt = 0;
    logic [7:0]  cap_q[$];
    int          cap_cyc[$];

    udm_uart_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .rx_i        (rx),
        .bit_div_i   (bit_div),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .rready_i    (rready),
        .frame_err_o (frame_err),
        .ovf_o       (ovf),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every handshake and count error/overflow pulse cycles.
    always @(negedge clk) begin
        if (rvalid && rready) begin
            cap_q.push_back(rdata);
            cap_cyc.push_back(cyc);
        end
        if (frame_err) ferr_cnt++;
        if (ovf) ovf_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cap_at(input int idx);
        if (idx < cap_q.size()) return 32'(cap_q[idx]);
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(DIV);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef UDM_UART_RX_PARITY_EN
        send_bit(^data);
`endif
        send_bit(stop_bit);
    endtask

`ifdef UDM_UART_RX_PARITY_EN
    task automatic send_parity_frame(input logic [7:0] data, input logic par_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(par_bit);
        send_bit(1'b1);
    endtask
`endif

    initial begin
        #(10 * 150000);
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int base;
        int f0;
        int o0;
        int start;
        int lat;

        arst_n  = 1'b0;
        rx      = 1'b1;
        rready  = 1'b0;
        bit_div = 32'(DIV);
        tick(3);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        arst_n = 1'b1;
        tick(2);

        // Single clean byte with latency bound.
        rready = 1'b1;
        base = cap_q.size(); f0 = ferr_cnt; o0 = ovf_cnt; start = cyc;
        send_frame(8'h55, 1'b1);
        tick(4);
        lat = (cap_cyc.size() > base) ? cap_cyc[base] - start : 999999;
        check("t1_count", 32'(cap_q.size() - base), 32'd1);
        check("t1_data", cap_at(base), 32'h55);
        check("t1_lat_le_max", 32'(lat <= int'(LAT_MAX)), 32'd1);
        check("t1_lat_ge_centre", 32'(lat >= int'(LAT_MIN)), 32'd1);
        check("t1_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t1_no_ovf", 32'(ovf_cnt - o0), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // Short low glitch is ignored silently.
        base = cap_q.size(); f0 = ferr_cnt;
        rx = 1'b0;
        tick(100);
        rx = 1'b1;
        tick(600);
        check("t2_count", 32'(cap_q.size() - base), 32'd0);
        check("t2_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        check("t2_idle", 32'(busy), 32'd0);

        // Bad stop bit drops the byte, next byte still received.
        base = cap_q.size(); f0 = ferr_cnt; o0 = ovf_cnt;
        send_frame(8'hA5, 1'b0);
        rx = 1'b1;
        tick(2 * DIV);
        send_frame(8'h3C, 1'b1);
        tick(4);
        check("t3_ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
        check("t3_count", 32'(cap_q.size() - base), 32'd1);
        check("t3_data", cap_at(base), 32'h3C);
        check("t3_no_ovf", 32'(ovf_cnt - o0), 32'd0);

        // Fill past capacity with the consumer stalled.
        rready = 1'b0;
        base = cap_q.size(); f0 = ferr_cnt; o0 = ovf_cnt;
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1);
        tick(4);
        check("t4_ovf_pulse", 32'(ovf_cnt - o0), 32'd1);
        check("t4_rvalid", 32'(rvalid), 32'd1);
        check("t4_head", 32'(rdata), 32'h01);
        tick(10);
        check("t4_head_stable", 32'(rdata), 32'h01);
        rready = 1'b1;
        tick(8);
        check("t4_count", 32'(cap_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) check($sformatf("t4_pop%0d", k), cap_at(base + k), 32'(k + 1));
        check("t4_empty", 32'(rvalid), 32'd0);
        check("t4_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Reset in the middle of data bit 4 aborts the frame.
        base = cap_q.size(); f0 = ferr_cnt;
        send_bit(1'b0);
        rx = 1'b0;
        tick(4 * DIV + DIV / 2);
        check("t5_busy_before", 32'(busy), 32'd1);
        arst_n = 1'b0;
        rx     = 1'b1;
        tick(1);
        check("t5_rst_rvalid", 32'(rvalid), 32'd0);
        check("t5_rst_rdata", 32'(rdata), 32'd0);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        check("t5_rst_ovf", 32'(ovf), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        tick(2);
        arst_n = 1'b1;
        tick(2 * DIV);
        send_frame(8'h7E, 1'b1);
        tick(4);
        check("t5_count", 32'(cap_q.size() - base), 32'd1);
        check("t5_data", cap_at(base), 32'h7E);
        check("t5_no_ferr", 32'(ferr_cnt - f0), 32'd0);

`ifdef UDM_UART_RX_PARITY_EN
        // Even parity: correct bit delivers, wrong bit drops with an error.
        base = cap_q.size(); f0 = ferr_cnt;
        send_parity_frame(8'h0F, 1'b0);
        tick(4);
        check("t6_good_count", 32'(cap_q.size() - base), 32'd1);
        check("t6_good_data", cap_at(base), 32'h0F);
        check("t6_good_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        base = cap_q.size(); f0 = ferr_cnt;
        send_parity_frame(8'h0F, 1'b1);
        tick(4);
        check("t6_bad_ferr", 32'(ferr_cnt - f0), 32'd1);
        check("t6_bad_count", 32'(cap_q.size() - base), 32'd0);
        check("t6_bad_idle", 32'(busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_udm_uart_rx
